aes_job_arbiter: RTL and testbench

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

---
 rtl/aes_ctrl_pkg.sv | 20 ++
 rtl/aes_job_arbiter_if.sv | 56 +++++
 rtl/rr_arb2.sv | 24 ++
 rtl/aes_job_arbiter.sv | 116 +++++++++++
 tb/tb_aes_job_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// AES job arbiter shared control definitions.
// Job states, cipher mode codes and wait counter width.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int CNT_W = $clog2(16);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [127:0] blk_t;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Job request, response and shared-core bundle.
// slave = the arbiter, master = requesters, consumer and core pair.
interface aes_job_arbiter_if #(
  parameter int Nk = 4
);
  import aes_ctrl_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic            req0_mode;
  blk_t            req0_data;
  logic [32*Nk-1:0] req0_key;

  logic            req1_valid;
  logic            req1_ready;
  logic            req1_mode;
  blk_t            req1_data;
  logic [32*Nk-1:0] req1_key;

  blk_t            core_in;
  logic [32*Nk-1:0] core_key;
  blk_t            core_enc_out;
  blk_t            core_dec_out;

  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  blk_t            rsp_data;

  modport slave (
    input  req0_valid, req0_mode,
    input  req0_data, req0_key,
    output req0_ready,
    input  req1_valid, req1_mode,
    input  req1_data, req1_key,
    output req1_ready,
    output core_in, core_key,
    input  core_enc_out, core_dec_out,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_mode,
    output req0_data, req0_key,
    input  req0_ready,
    output req1_valid, req1_mode,
    output req1_data, req1_key,
    input  req1_ready,
    input  core_in, core_key,
    output core_enc_out, core_dec_out,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// On a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      valid0 && valid1:
        grant = last_grant ? 2'b01 : 2'b10;
      valid0 && !valid1:
        grant = 2'b01;
      !valid0 && valid1:
        grant = 2'b10;
      default:
        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one external Cipher/InvCipher pair between two requesters.
// Fixed-latency flow IDLE -> LOAD -> WAIT -> RESP.
module aes_job_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int Nk       = 4,
  parameter int CORE_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  output logic busy,
  aes_job_arbiter_if.slave bus
);

  localparam int   KW     = 32 * Nk;
  localparam cnt_t LAT_M1 = cnt_t'(CORE_LAT - 1);

  state_t        state;
  cnt_t          wait_cnt;
  logic          last_grant;
  logic          mode;
  logic          id;
  logic          rsp_valid;
  logic          rsp_id;
  blk_t          rsp_data;
  blk_t          core_in;
  logic [KW-1:0] core_key;
  logic [1:0]    grant;
  logic [1:0]    ready;
  logic          take;
  blk_t          sel_data;
  logic [KW-1:0] sel_key;
  logic          sel_mode;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // reset and flush both mask the combinational ready
  assign ready = (reset && !flush && state == IDLE)
               ? grant : 2'b00;
  assign take  = |ready;

  assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;
  assign sel_key  = grant[1] ? bus.req1_key  : bus.req0_key;
  assign sel_mode = grant[1] ? bus.req1_mode : bus.req0_mode;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= 1'b1;
      mode       <= MODE_ENC;
      id         <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      core_in    <= '0;
      core_key   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            core_in    <= sel_data;
            core_key   <= sel_key;
            mode       <= sel_mode;
            id         <= ready[1];
            last_grant <= ready[1];
            state      <= LOAD;
          end
        end
        LOAD: begin
          wait_cnt <= LAT_M1;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_data  <= (mode == MODE_DEC)
                       ? bus.core_dec_out
                       : bus.core_enc_out;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - cnt_t'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.core_in    = core_in;
  assign bus.core_key   = core_key;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_data   = rsp_data;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter with an AES-128 core pair model.
// Jobs are predicted from grant rules and fixed latency.
module tb_aes_job_arbiter;
  import aes_ctrl_pkg::*;

  localparam int CL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic busy;

  int   tests = 0;
  int   fails = 0;
  logic lg;
  bit   noisy = 1'b0;

  logic [127:0] enc_q = '0;
  logic [127:0] dec_q = '0;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];

  aes_job_arbiter_if #(.Nk(4)) bus ();

  aes_job_arbiter #(
    .Nk       (4),
    .CORE_LAT (CL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // ---------------- AES-128 Cipher / InvCipher ----------------
  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b)
               : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  task automatic init_tables();
    logic [7:0] x, p, s;
    for (int a = 0; a < 256; a++) begin
      x = 8'(a);
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, x);
      s = p ^ rotl(p, 1) ^ rotl(p, 2)
            ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
      sb[a]  = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [1407:0] expand(
    input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]],
             sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++)
      ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      o[127-8*i -: 8] = inv ? isb[b] : sb[b];
    end
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(
    input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(
    input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   a  [4];
    logic [7:0]   cf [4];
    logic [7:0]   v;
    if (inv) begin
      cf[0] = 8'd14; cf[1] = 8'd11;
      cf[2] = 8'd13; cf[3] = 8'd9;
    end else begin
      cf[0] = 8'd2; cf[1] = 8'd3;
      cf[2] = 8'd1; cf[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++)
        a[j] = s[127-8*(4*c+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        v = '0;
        for (int j = 0; j < 4; j++)
          v = v ^ gmul(cf[(j - r + 4) % 4], a[j]);
        o[127-8*(4*c+r) -: 8] = v;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] cipher(
    input logic [127:0] d, input logic [127:0] k);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand(k);
    s  = d ^ ks[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      s = sub_bytes(s, 1'b0);
      s = shift_rows(s, 1'b0);
      if (r != 10) s = mix(s, 1'b0);
      s = s ^ ks[1407-128*r -: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] inv_cipher(
    input logic [127:0] d, input logic [127:0] k);
    logic [1407:0] ks;
    logic [127:0]  s;
    ks = expand(k);
    s  = d ^ ks[1407-1280 -: 128];
    for (int r = 9; r >= 0; r--) begin
      s = shift_rows(s, 1'b1);
      s = sub_bytes(s, 1'b1);
      s = s ^ ks[1407-128*r -: 128];
      if (r != 0) s = mix(s, 1'b1);
    end
    return s;
  endfunction

  // core pair settles within half a cycle of a new capture
  always @(negedge clock) begin
    enc_q <= cipher(bus.core_in, bus.core_key);
    dec_q <= inv_cipher(bus.core_in, bus.core_key);
  end

  assign bus.core_enc_out = enc_q;
  assign bus.core_dec_out = dec_q;

  // ---------------- checking helpers ----------------
  task automatic check(input string tag,
    input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag,
    input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic no_ready(input string tag);
    check1({tag, "_ready0"}, bus.req0_ready, 1'b0);
    check1({tag, "_ready1"}, bus.req1_ready, 1'b0);
  endtask

  task automatic wiggle();
    if (noisy) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // abort: 0 none, 1 flush in WAIT, 2 reset pulse in RESP
  task automatic job(
    input logic v0, input logic v1,
    input logic m0, input logic m1,
    input logic [127:0] d0, input logic [127:0] d1,
    input logic [127:0] k0, input logic [127:0] k1,
    input int bp, input int abort,
    output logic [127:0] got);
    int w;
    logic [127:0] ed, ek, exp;
    logic em;
    got = '0;
    w  = (v0 && v1) ? (lg ? 0 : 1) : (v1 ? 1 : 0);
    ed = (w == 1) ? d1 : d0;
    ek = (w == 1) ? k1 : k0;
    em = (w == 1) ? m1 : m0;
    exp = (em == MODE_DEC) ? inv_cipher(ed, ek)
                           : cipher(ed, ek);
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_mode  = m0; bus.req1_mode  = m1;
    bus.req0_data  = d0; bus.req1_data  = d1;
    bus.req0_key   = k0; bus.req1_key   = k1;
    bus.rsp_ready  = 1'b0;
    #1;
    check1("grant0", bus.req0_ready, w == 0);
    check1("grant1", bus.req1_ready, w == 1);
    check1("onehot", bus.req0_ready & bus.req1_ready,
           1'b0);
    lg = (w == 1);
    tick();
    wiggle();
    #1;
    check1("load_busy", busy, 1'b1);
    check("core_in", bus.core_in, ed);
    check("core_key", bus.core_key, ek);
    check1("load_rsp", bus.rsp_valid, 1'b0);
    no_ready("load");
    for (int i = 2; i <= CL + 1; i++) begin
      tick();
      wiggle();
      if (abort == 1 && i == 2) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check1("flush_busy", busy, 1'b0);
        check1("flush_rsp", bus.rsp_valid, 1'b0);
        for (int j = 0; j < 4; j++) begin
          tick();
          check1("flush_norsp", bus.rsp_valid, 1'b0);
        end
        return;
      end
      #1;
      check1("wait_rsp", bus.rsp_valid, 1'b0);
      check1("wait_busy", busy, 1'b1);
      no_ready("wait");
    end
    tick();
    wiggle();
    #1;
    check1("rsp_valid", bus.rsp_valid, 1'b1);
    check1("rsp_id", bus.rsp_id, w == 1);
    check("rsp_data", bus.rsp_data, exp);
    no_ready("resp");
    got = bus.rsp_data;
    if (abort == 2) begin
      reset = 1'b0;
      #1;
      check1("rst_rsp", bus.rsp_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      no_ready("rst");
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #2;
      reset = 1'b1;
      lg = 1'b1;
      return;
    end
    for (int i = 0; i < bp; i++) begin
      tick();
      wiggle();
      #1;
      check1("bp_valid", bus.rsp_valid, 1'b1);
      check("bp_data", bus.rsp_data, exp);
      check1("bp_id", bus.rsp_id, w == 1);
      check("bp_core", bus.core_in, ed);
      no_ready("bp");
    end
    bus.rsp_ready = 1'b1;
    #1;
    no_ready("hs");
    tick();
    bus.rsp_ready = 1'b0;
    check1("done_rsp", bus.rsp_valid, 1'b0);
    check1("done_busy", busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  logic [127:0] key, pt, ct, got, d0, d1, k0, k1;
  int pat;

  initial begin
    init_tables();
    key = 128'h000102030405060708090a0b0c0d0e0f;
    pt  = 128'h00112233445566778899aabbccddeeff;
    ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_mode  = 1'b0; bus.req1_mode  = 1'b0;
    bus.req0_data  = '0;   bus.req1_data  = '0;
    bus.req0_key   = '0;   bus.req1_key   = '0;
    bus.rsp_ready  = 1'b0;
    lg = 1'b1;

    #1 reset = 1'b0;
    #2;
    check1("rst_valid", bus.rsp_valid, 1'b0);
    check1("rst_id", bus.rsp_id, 1'b0);
    check("rst_data", bus.rsp_data, '0);
    check("rst_core_in", bus.core_in, '0);
    check("rst_core_key", bus.core_key, '0);
    check1("rst_busy0", busy, 1'b0);
    no_ready("rst0");
    #9;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    tick();

    job(1'b1, 1'b0, MODE_ENC, MODE_ENC, pt, '0,
        key, '0, 0, 0, got);
    check("enc_vector", got, ct);
    job(1'b0, 1'b1, MODE_ENC, MODE_DEC, '0, ct,
        '0, key, 0, 0, got);
    check("dec_vector", got, pt);

    job(1'b1, 1'b1, MODE_ENC, MODE_DEC, rnd128(),
        rnd128(), rnd128(), rnd128(), 10, 0, got);

    job(1'b1, 1'b0, MODE_ENC, MODE_ENC, rnd128(),
        '0, rnd128(), '0, 0, 1, got);
    job(1'b0, 1'b1, MODE_ENC, MODE_DEC, '0, ct,
        '0, key, 0, 0, got);
    check("post_flush", got, pt);

    job(1'b1, 1'b0, MODE_ENC, MODE_ENC, pt, '0,
        key, '0, 0, 2, got);
    tick();

    for (int n = 0; n < 4; n++) begin
      job(1'b1, 1'b1, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), rnd128(),
          rnd128(), rnd128(), rnd128(),
          $urandom_range(0, 2), 0, got);
      check1("tie_order", lg, 1'(n % 2));
    end

    noisy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      pat = $urandom_range(1, 3);
      d0 = rnd128(); d1 = rnd128();
      k0 = rnd128(); k1 = rnd128();
      job(pat[0], pat[1], 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), d0, d1, k0, k1,
          $urandom_range(0, 3), 0, got);
    end
    noisy = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check1("end_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
